// File: rtl/qpd_position_normalizer.sv
// Normalised quad-photodiode beam position.
// On each tick the four quadrant samples are latched. The block then forms
//   sum = q1+q2+q3+q4
//   x   = ((q1+q4)-(q2+q3))/sum
//   y   = ((q1+q2)-(q3+q4))/sum
// as signed fractions, where full scale is 2^(NUM_BITS_OUT-1). Two restoring
// dividers run in parallel. The latency from tick to done is always
// NUM_BITS_OUT+1 cycles.
//
// Ports:
//   clk_i, reset_i     clock, async active-low reset
//   tick_i             one-cycle strobe, q1_i..q4_i valid
//   q1_i..q4_i         signed quadrant samples
//   x_o, y_o           signed normalised position
//   sum_o              signed quadrant sum of the current result
//   low_light_o        sum below SUM_MIN, position forced to zero
//   sat_o              at least one axis clamped to +/-(full scale - 1)
//   busy_o             a computation is in flight
//   dropped_o          one-cycle pulse: tick_i arrived while busy
//   done_o             one-cycle pulse: outputs updated
module qpd_position_normalizer #(
  parameter int unsigned NUM_BITS_IN  = 24,
  parameter int unsigned NUM_BITS_OUT = 24,
  parameter int          SUM_MIN      = 1024
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           tick_i,
  input  logic signed [NUM_BITS_IN-1:0]  q1_i,
  input  logic signed [NUM_BITS_IN-1:0]  q2_i,
  input  logic signed [NUM_BITS_IN-1:0]  q3_i,
  input  logic signed [NUM_BITS_IN-1:0]  q4_i,
  output logic signed [NUM_BITS_OUT-1:0] x_o,
  output logic signed [NUM_BITS_OUT-1:0] y_o,
  output logic signed [NUM_BITS_IN+1:0]  sum_o,
  output logic                           low_light_o,
  output logic                           sat_o,
  output logic                           busy_o,
  output logic                           dropped_o,
  output logic                           done_o
);

  localparam int unsigned SW = NUM_BITS_IN + 2;       // sum / difference width
  localparam int unsigned QW = NUM_BITS_OUT - 1;      // quotient magnitude bits
  localparam int unsigned CW = $clog2(NUM_BITS_OUT);  // divide step counter

  localparam logic [NUM_BITS_OUT-1:0] MAG_MAX = {1'b0, {QW{1'b1}}};

  typedef enum logic [1:0] {IDLE, PREP, DIV, OUT} state_t;

  state_t state, state_nxt;

  logic signed [NUM_BITS_IN-1:0] q1_r, q2_r, q3_r, q4_r;
  logic signed [SW-1:0]          sum_r;
  logic [SW-1:0]                 rem_x, rem_y;
  logic [QW-1:0]                 quo_x, quo_y;
  logic [CW-1:0]                 cnt;
  logic                          sign_x, sign_y, sat_x, sat_y, low_light_r;

  logic signed [SW-1:0]          sum_c, dx_c, dy_c;
  logic [SW-1:0]                 dx_mag_c, dy_mag_c;
  logic [SW:0]                   sum_ext_c, dbl_x_c, dbl_y_c, diff_x_c, diff_y_c;
  logic                          ge_x_c, ge_y_c;
  logic [SW-1:0]                 rem_x_nxt_c, rem_y_nxt_c;
  logic [NUM_BITS_OUT-1:0]       mag_x_c, mag_y_c, x_c, y_c;
  logic                          accept_c, drop_c;

  // Sequencing: latch on tick, one prep cycle, QW divide steps, one output cycle
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    drop_c    = 1'b0;
    case (state)
      IDLE: begin
        if (tick_i) begin
          accept_c  = 1'b1;
          state_nxt = PREP;
        end
      end
      PREP: state_nxt = DIV;
      DIV:  if (cnt == CW'(QW - 1)) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tick_i && (state != IDLE)) drop_c = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Sum and axis differences. The NUM_BITS_IN+2 bit width cannot overflow.
  always_comb begin
    sum_c    = SW'(q1_r) + SW'(q2_r) + SW'(q3_r) + SW'(q4_r);
    dx_c     = (SW'(q1_r) + SW'(q4_r)) - (SW'(q2_r) + SW'(q3_r));
    dy_c     = (SW'(q1_r) + SW'(q2_r)) - (SW'(q3_r) + SW'(q4_r));
    dx_mag_c = dx_c[SW-1] ? $unsigned(-dx_c) : $unsigned(dx_c);
    dy_mag_c = dy_c[SW-1] ? $unsigned(-dy_c) : $unsigned(dy_c);
  end

  // One restoring-division step per axis: shift the remainder, subtract if it fits.
  always_comb begin
    sum_ext_c   = {1'b0, $unsigned(sum_r)};
    dbl_x_c     = {rem_x, 1'b0};
    dbl_y_c     = {rem_y, 1'b0};
    diff_x_c    = dbl_x_c - sum_ext_c;
    diff_y_c    = dbl_y_c - sum_ext_c;
    ge_x_c      = dbl_x_c >= sum_ext_c;
    ge_y_c      = dbl_y_c >= sum_ext_c;
    rem_x_nxt_c = ge_x_c ? diff_x_c[SW-1:0] : dbl_x_c[SW-1:0];
    rem_y_nxt_c = ge_y_c ? diff_y_c[SW-1:0] : dbl_y_c[SW-1:0];
  end

  // Final magnitude selection and sign. Low light takes priority over saturation.
  always_comb begin
    mag_x_c = low_light_r ? '0 : (sat_x ? MAG_MAX : {1'b0, quo_x});
    mag_y_c = low_light_r ? '0 : (sat_y ? MAG_MAX : {1'b0, quo_y});
    x_c     = sign_x ? -mag_x_c : mag_x_c;
    y_c     = sign_y ? -mag_y_c : mag_y_c;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q1_r        <= '0;
      q2_r        <= '0;
      q3_r        <= '0;
      q4_r        <= '0;
      sum_r       <= '0;
      rem_x       <= '0;
      rem_y       <= '0;
      quo_x       <= '0;
      quo_y       <= '0;
      cnt         <= '0;
      sign_x      <= 1'b0;
      sign_y      <= 1'b0;
      sat_x       <= 1'b0;
      sat_y       <= 1'b0;
      low_light_r <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      sum_o       <= '0;
      low_light_o <= 1'b0;
      sat_o       <= 1'b0;
      busy_o      <= 1'b0;
      dropped_o   <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      busy_o    <= (state_nxt != IDLE);
      dropped_o <= drop_c;
      done_o    <= (state == OUT);
      case (state)
        IDLE: begin
          if (accept_c) begin
            q1_r <= q1_i;
            q2_r <= q2_i;
            q3_r <= q3_i;
            q4_r <= q4_i;
          end
        end
        PREP: begin
          sum_r       <= sum_c;
          rem_x       <= dx_mag_c;
          rem_y       <= dy_mag_c;
          sign_x      <= dx_c[SW-1];
          sign_y      <= dy_c[SW-1];
          low_light_r <= (sum_c < SW'(SUM_MIN));
          // This compare only matters when sum >= SUM_MIN >= 1, so sum is positive here.
          sat_x       <= (dx_mag_c >= $unsigned(sum_c));
          sat_y       <= (dy_mag_c >= $unsigned(sum_c));
          quo_x       <= '0;
          quo_y       <= '0;
          cnt         <= '0;
        end
        DIV: begin
          rem_x <= rem_x_nxt_c;
          rem_y <= rem_y_nxt_c;
          quo_x <= {quo_x[QW-2:0], ge_x_c};
          quo_y <= {quo_y[QW-2:0], ge_y_c};
          cnt   <= cnt + CW'(1);
        end
        OUT: begin
          x_o         <= $signed(x_c);
          y_o         <= $signed(y_c);
          sum_o       <= sum_r;
          low_light_o <= low_light_r;
          sat_o       <= ~low_light_r & (sat_x | sat_y);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qpd_position_normalizer.sv
// Scoreboard bench for qpd_position_normalizer. Each accepted tick pushes the
// result computed by an arithmetic reference model. A monitor pops and compares
// the expected entry on every done_o pulse, including the cycle of arrival.
module tb_qpd_position_normalizer;

  localparam int unsigned NI   = 24;
  localparam int unsigned NO   = 24;
  localparam int          SMIN = 1024;
  localparam int          LAT  = NO + 1;
  localparam longint      FS   = longint'(1) << (NO - 1);

  typedef struct {
    longint x;
    longint y;
    longint sum;
    longint ll;
    longint sat;
    longint due;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tick = 1'b0;
  logic signed [NI-1:0] q1 = '0, q2 = '0, q3 = '0, q4 = '0;
  logic signed [NO-1:0] x_o, y_o;
  logic signed [NI+1:0] sum_o;
  logic                 low_light_o, sat_o, busy_o, dropped_o, done_o;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          drop_exp = 0;
  int          drop_seen = 0;
  exp_t        sb[$];

  qpd_position_normalizer #(
    .NUM_BITS_IN (NI),
    .NUM_BITS_OUT(NO),
    .SUM_MIN     (SMIN)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst_n),
    .tick_i     (tick),
    .q1_i       (q1),
    .q2_i       (q2),
    .q3_i       (q3),
    .q4_i       (q4),
    .x_o        (x_o),
    .y_o        (y_o),
    .sum_o      (sum_o),
    .low_light_o(low_light_o),
    .sat_o      (sat_o),
    .busy_o     (busy_o),
    .dropped_o  (dropped_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic. SV division truncates toward zero.
  function automatic longint axis(input longint d, input longint s, output longint sat);
    longint ad;
    ad  = (d < 0) ? -d : d;
    sat = 0;
    if (ad >= s) begin
      sat = 1;
      return (d < 0) ? -(FS - 1) : (FS - 1);
    end
    return (d * FS) / s;
  endfunction

  function automatic exp_t model(input longint a, input longint b, input longint c, input longint d);
    exp_t   e;
    longint sx, sy;
    e.sum = a + b + c + d;
    e.ll  = 0;
    e.sat = 0;
    e.due = 0;
    if (e.sum < SMIN) begin
      e.x  = 0;
      e.y  = 0;
      e.ll = 1;
    end else begin
      e.x   = axis((a + d) - (b + c), e.sum, sx);
      e.y   = axis((a + b) - (c + d), e.sum, sy);
      e.sat = (sx != 0 || sy != 0) ? 1 : 0;
    end
    return e;
  endfunction

  // Monitor: compare on every done pulse and count dropped pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dropped_o) drop_seen++;
      if (done_o) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: done_o=1 with no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("latency", longint'(cyc), e.due);
          check("x", longint'(x_o), e.x);
          check("y", longint'(y_o), e.y);
          check("sum", longint'(sum_o), e.sum);
          check("low_light", longint'(low_light_o), e.ll);
          check("sat", longint'(sat_o), e.sat);
        end
      end
    end
  end

  // Present one tick. The posedge between the two negedges samples it.
  task automatic send(input int a, input int b, input int c, input int d, input bit acc);
    exp_t e;
    @(negedge clk);
    q1   = NI'(a);
    q2   = NI'(b);
    q3   = NI'(c);
    q4   = NI'(d);
    tick = 1'b1;
    if (acc) begin
      e     = model(longint'(a), longint'(b), longint'(c), longint'(d));
      e.due = longint'(cyc) + 1 + LAT;
      sb.push_back(e);
    end else begin
      drop_exp++;
    end
    @(negedge clk);
    tick = 1'b0;
    if (acc) check("busy_after_tick", longint'(busy_o), 1);
    else     check("dropped_pulse", longint'(dropped_o), 1);
  endtask

  // Ticks sampled n cycles apart (n >= 2) when placed between two sends.
  task automatic gap(input int n);
    repeat (n - 2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, longint'(x_o), 0);
    check({tag, "_y"}, longint'(y_o), 0);
    check({tag, "_sum"}, longint'(sum_o), 0);
    check({tag, "_low_light"}, longint'(low_light_o), 0);
    check({tag, "_sat"}, longint'(sat_o), 0);
    check({tag, "_busy"}, longint'(busy_o), 0);
    check({tag, "_dropped"}, longint'(dropped_o), 0);
    check({tag, "_done"}, longint'(done_o), 0);
  endtask

  function automatic int rnd_q(input int mode);
    logic signed [NI-1:0] t;
    if (mode <= 6)      t = NI'($urandom_range(0, 4194303));
    else if (mode == 7) t = NI'($urandom_range(0, 400));
    else                t = NI'($urandom());
    return int'(t);
  endfunction

  initial begin
    int v[4];
    int mode;
    int waited;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    send(1000000, 1000000, 1000000, 1000000, 1'b1); gap(26);
    send(300000, 100000, 100000, 300000, 1'b1);     gap(26);
    send(100000, 300000, 300000, 100000, 1'b1);     gap(26);
    send(2000000, 1000000, 1000000, 2000000, 1'b1); gap(26);
    send(1000000, 2000000, 2000000, 1000000, 1'b1); gap(26);
    send(1000000, 0, 0, 0, 1'b1);                   gap(26);
    send(0, 0, 1000000, 0, 1'b1);                   gap(26);
    send(200, 200, 200, 200, 1'b1);                 gap(26);
    send(1023, 0, 0, 0, 1'b1);                      gap(26);
    send(1024, 0, 0, 0, 1'b1);                      gap(26);
    send(-5000, 3000, 2000, 1500, 1'b1);            gap(26);

    // Overrun five cycles into a computation
    send(300000, 100000, 100000, 300000, 1'b1); gap(5);
    send(7, 7, 7, 7, 1'b0);                     gap(21);
    // Tick on the output cycle is dropped; next free cycle is accepted
    send(2000000, 1000000, 1000000, 2000000, 1'b1); gap(25);
    send(9, 9, 9, 9, 1'b0);                         gap(2);
    send(123456, 654321, 111111, 222222, 1'b1);     gap(26);
    send(500000, 400000, 300000, 200000, 1'b1);     gap(26);
    check("drop_count_overrun", longint'(drop_seen), longint'(drop_exp));

    // Reset in the middle of the divide phase
    send(1000000, 0, 0, 0, 1'b1);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send(300000, 100000, 100000, 300000, 1'b1); gap(26);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 9));
      for (int j = 0; j < 4; j++) v[j] = rnd_q(mode);
      send(v[0], v[1], v[2], v[3], 1'b1);
      gap(26 + int'($urandom_range(0, 3)));
    end

    // Drain with a bound
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", longint'(sb.size()), 0);
    check("drop_count_final", longint'(drop_seen), longint'(drop_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
